fwd_hazard_unit: RTL



---
 rtl/fwd_hazard_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the miniRV ID stage, with a stall watchdog.
// Define FWD_PERF_CNT_EN to add the stall_cnt performance counter port.
module fwd_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int NRP        = 2,
    parameter int NSTG       = 3,
    parameter int HIST_DEPTH = 1,
    parameter int STALL_MAX  = 4
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    input  logic [NRP*5-1:0]     id_rs_addr,
    input  logic [NRP-1:0]       id_rs_used,
    input  logic [NSTG-1:0]      stg_we,
    input  logic [NSTG*5-1:0]    stg_rd,
    input  logic [NSTG*XLEN-1:0] stg_wd,
    input  logic [NSTG-1:0]      stg_wd_ok,
    output logic [NRP-1:0]       fwd_en,
    output logic [NRP*XLEN-1:0]  fwd_data,
    output logic                 stall,
    output logic                 stall_timeout
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int HD     = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;
    localparam int SCNT_W = $clog2(STALL_MAX + 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STALL_MAX);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] STALLED = 1'b1;

    logic [HD-1:0]   hv_q;
    logic [4:0]      hrd_q [HD];
    logic [XLEN-1:0] hwd_q [HD];

    // Retired-write history: entry 0 is the most recent WB write, advanced every cycle.
    generate
        if (HIST_DEPTH > 0) begin : g_hist
            always_ff @(posedge cpu_clk or negedge cpu_rst) begin
                if (!cpu_rst) begin
                    hv_q <= '0;
                end else begin
                    hv_q[0] <= stg_we[NSTG-1] & (stg_rd[(NSTG-1)*5 +: 5] != 5'd0);
                    for (int i = 1; i < HIST_DEPTH; i++) begin
                        hv_q[i] <= hv_q[i-1];
                    end
                end
            end

            always_ff @(posedge cpu_clk) begin
                hrd_q[0] <= stg_rd[(NSTG-1)*5 +: 5];
                hwd_q[0] <= stg_wd[(NSTG-1)*XLEN +: XLEN];
                for (int i = 1; i < HIST_DEPTH; i++) begin
                    hrd_q[i] <= hrd_q[i-1];
                    hwd_q[i] <= hwd_q[i-1];
                end
            end
        end else begin : g_nohist
            assign hv_q     = '0;
            assign hrd_q[0] = '0;
            assign hwd_q[0] = '0;
        end
    endgenerate

    logic [NRP-1:0]  hit_c;
    logic [NRP-1:0]  ok_c;
    logic [XLEN-1:0] dat_c [NRP];

    // Scan lowest priority first so the youngest producer overwrites older matches.
    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            hit_c[p] = 1'b0;
            ok_c[p]  = 1'b0;
            dat_c[p] = '0;
            if (id_rs_used[p] && (id_rs_addr[p*5 +: 5] != 5'd0)) begin
                for (int h = HIST_DEPTH - 1; h >= 0; h--) begin
                    if (hv_q[h] && (hrd_q[h] == id_rs_addr[p*5 +: 5])) begin
                        hit_c[p] = 1'b1;
                        ok_c[p]  = 1'b1;
                        dat_c[p] = hwd_q[h];
                    end
                end
                for (int s = NSTG - 1; s >= 0; s--) begin
                    if (stg_we[s] && (stg_rd[s*5 +: 5] == id_rs_addr[p*5 +: 5])) begin
                        hit_c[p] = 1'b1;
                        ok_c[p]  = stg_wd_ok[s];
                        dat_c[p] = stg_wd[s*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        fwd_en   = '0;
        fwd_data = '0;
        stall    = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            fwd_en[p]                 = hit_c[p] & ok_c[p];
            fwd_data[p*XLEN +: XLEN]  = (hit_c[p] && ok_c[p]) ? dat_c[p] : '0;
            stall                     = stall | (hit_c[p] & ~ok_c[p]);
        end
    end

    logic [0:0]        state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              timeout_q, timeout_d;

    // Watchdog: timeout latches on the edge where the stall run reaches STALL_MAX.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            RUN: begin
                if (stall) begin
                    state_d = STALLED;
                    scnt_d  = SCNT_W'(1);
                end
            end
            default: begin
                if (stall) begin
                    if (scnt_q != SCNT_MAX) scnt_d = scnt_q + SCNT_W'(1);
                end else begin
                    state_d = RUN;
                    scnt_d  = '0;
                end
            end
        endcase
        timeout_d = timeout_q | (stall & (scnt_d == SCNT_MAX));
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q   <= RUN;
            scnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = stall ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`endif

endmodule
